// File: rtl/dmem_responder.sv
// Word-organised byte-writable data RAM with a fixed-latency response pipeline.
// Optional tohost MMIO register, enabled with `define DMEM_MMIO_EN.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [31:0] TOHOST_ADDR  = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_be,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rvalid,
  output logic        dmem_err,
  output logic        tohost_valid,
  output logic [31:0] tohost_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } slot_t;

  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
      $error("dmem_responder: READ_LATENCY must be 1..4");
    end
  endgenerate

  logic [31:0]           mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  in_range;
  logic                  hit_th;
  logic                  ram_wr;
  logic [31:0]           th_data;
  logic                  th_vld;

  assign idx      = dmem_addr[ADDR_WIDTH+1:2];
  assign in_range = (dmem_addr[31:ADDR_WIDTH+2] == '0);
  assign ram_wr   = dmem_req & dmem_we & in_range
                  & ~hit_th & ~rst;

`ifdef DMEM_MMIO_EN
  logic [31:0] th_data_q, th_data_d;
  logic        th_vld_q, th_vld_d;

  assign hit_th = (dmem_addr[31:2] == TOHOST_ADDR[31:2]);

  always_comb begin
    th_vld_d  = dmem_req & dmem_we & hit_th
              & (dmem_be == 4'hF);
    th_data_d = th_vld_d ? dmem_wdata : th_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      th_vld_q  <= 1'b0;
      th_data_q <= '0;
    end else begin
      th_vld_q  <= th_vld_d;
      th_data_q <= th_data_d;
    end
  end

  assign th_vld  = th_vld_q;
  assign th_data = th_data_q;
`else
  assign hit_th  = 1'b0;
  assign th_vld  = 1'b0;
  assign th_data = '0;
`endif

  assign tohost_valid = th_vld;
  assign tohost_data  = th_data;

  // Array is deliberately not reset; only written lanes change.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_be[b]) begin
          mem_q[idx][8*b +: 8] <= dmem_wdata[8*b +: 8];
        end
      end
    end
  end

  slot_t ent_d;

  always_comb begin
    ent_d = '0;
    if (dmem_req) begin
      ent_d.rd = ~dmem_we;
      if (hit_th) begin
        ent_d.err  = dmem_we & (dmem_be != 4'hF);
        ent_d.data = dmem_we ? 32'h0 : th_data;
      end else if (in_range) begin
        ent_d.data = dmem_we ? 32'h0 : mem_q[idx];
      end else begin
        ent_d.err = 1'b1;
      end
    end
  end

  slot_t slot_q [READ_LATENCY];
  slot_t pre_exit;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= ent_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  // rdata is loaded on the same edge a read enters the exit slot.
  generate
    if (READ_LATENCY == 1) begin : g_pre1
      assign pre_exit = ent_d;
    end else begin : g_pren
      assign pre_exit = slot_q[READ_LATENCY-2];
    end
  endgenerate

  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (pre_exit.rd) begin
      rdata_d = pre_exit.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign dmem_rdata  = rdata_q;
  assign dmem_rvalid = slot_q[READ_LATENCY-1].rd;
  assign dmem_err    = slot_q[READ_LATENCY-1].err;

  logic unused_ok;
  assign unused_ok = ^{dmem_addr[1:0],
                       slot_q[READ_LATENCY-1].data};

endmodule
